// File: rtl/key_debounce.sv
// Purpose: synchronize and debounce active-low push-buttons into clean levels and press/release/long-press strobes.
// Latency: key_press/key_state follow a stable input by CNT_MAX+3 edges counting the first sampling edge; key_release likewise.
// Backpressure: none; free-running pipeline, each strobe is a single-cycle pulse that is never held or retried.
module key_debounce #(
  parameter int          KEY_W    = 2,
  parameter logic [24:0] CNT_MAX  = 25'd1_000_000,
  parameter logic [25:0] LONG_MAX = 26'd50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic [KEY_W-1:0] key_in,
  output logic [KEY_W-1:0] key_state,
  output logic [KEY_W-1:0] key_press,
  output logic [KEY_W-1:0] key_release,
  output logic [KEY_W-1:0] key_long
);

  // Terminal counts; both parameters are at least 2 so these never wrap.
  localparam logic [24:0] CNT_LAST  = CNT_MAX - 25'd1;
  localparam logic [25:0] LONG_LAST = LONG_MAX - 26'd1;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } state_t;

  // One fully independent channel per key; nothing is shared between keys.
  for (genvar k = 0; k < KEY_W; k++) begin : g_key

    // Two-flop synchronizer; both stages idle at 1 (released pin level).
    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic ks;

    // Channel FSM and counters.
    state_t      state_q, state_d;
    logic [24:0] cnt_q, cnt_d;
    logic [25:0] hcnt_q, hcnt_d;

    // Registered outputs.
    logic level_q, level_d;
    logic press_q, press_d;
    logic rel_q, rel_d;
    logic long_q, long_d;

    // Synchronizer next values: shift the raw pin through two stages.
    always_comb begin
      sync1_d = key_in[k];
      sync2_d = sync1_q;
    end

    assign ks = sync2_q;

    // Synchronizer registers, reset to the released level.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        sync1_q <= 1'b1;
        sync2_q <= 1'b1;
      end else begin
        sync1_q <= sync1_d;
        sync2_q <= sync2_d;
      end
    end

    // Next-state and output logic; strobes default low so they last one cycle.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hcnt_d  = hcnt_q;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      long_d  = 1'b0;

      case (state_q)
        IDLE: begin
          if (!ks) begin
            state_d = PRESS_FILT;
            cnt_d   = 25'd0;
          end
        end

        PRESS_FILT: begin
          if (ks) begin
            // Input bounced back before the window closed: discard silently.
            state_d = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            state_d = DOWN;
            level_d = 1'b1;
            press_d = 1'b1;
            hcnt_d  = 26'd0;
          end else begin
            cnt_d = cnt_q + 25'd1;
          end
        end

        DOWN: begin
          if (ks) begin
            state_d = REL_FILT;
            cnt_d   = 25'd0;
          end else if (hcnt_q == LONG_LAST) begin
            // Park at LONG_MAX so the long strobe fires once per press.
            long_d = 1'b1;
            hcnt_d = LONG_MAX;
          end else if (hcnt_q < LONG_LAST) begin
            hcnt_d = hcnt_q + 26'd1;
          end
        end

        REL_FILT: begin
          if (!ks) begin
            // Release glitch: resume the press with the hold count untouched.
            state_d = DOWN;
          end else if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            level_d = 1'b0;
            rel_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + 25'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // FSM, counter and output registers; reset clears every output at once.
    always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
        state_q <= IDLE;
        cnt_q   <= 25'd0;
        hcnt_q  <= 26'd0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    assign key_state[k]   = level_q;
    assign key_press[k]   = press_q;
    assign key_release[k] = rel_q;
    assign key_long[k]    = long_q;

  end : g_key

endmodule

// File: tb/tb_key_debounce.sv
// Directed bench for key_debounce with CNT_MAX=25, LONG_MAX=100, 20 ns clock.
// Edges are numbered from 1; outputs are sampled on the falling edge.
module tb_key_debounce;

  localparam logic [24:0] CNT  = 25'd25;
  localparam logic [25:0] LNG  = 26'd100;
  localparam int          LAT  = 27;   // edges after the sampling edge (28th edge counting it)
  localparam int          LLAT = 100;  // press strobe to long strobe

  logic       sys_clk = 1'b0;
  logic       sys_rst;
  logic [1:0] key_in;
  logic [1:0] key_state, key_press, key_release, key_long;

  key_debounce #(.KEY_W(2), .CNT_MAX(CNT), .LONG_MAX(LNG)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #10 sys_clk = ~sys_clk;

  int edge_cnt = 0;
  always @(posedge sys_clk) edge_cnt <= edge_cnt + 1;

  int n_assert = 0;
  int n_fail   = 0;

  int press_n [2];
  int rel_n   [2];
  int long_n  [2];
  int press_at[2];
  int rel_at  [2];
  int long_at [2];
  int both_press_n;
  int busy_n;        // cycles with any output bit set
  int k1_busy_n;     // cycles with any key-1 output set
  int st0_hi_n;      // cycles with key_state[0]=1
  int st0_lo_n;      // cycles with key_state[0]=0
  int st0_rise_at;

  task automatic clr();
    for (int k = 0; k < 2; k++) begin
      press_n[k] = 0; rel_n[k] = 0; long_n[k] = 0;
      press_at[k] = -1; rel_at[k] = -1; long_at[k] = -1;
    end
    both_press_n = 0; busy_n = 0; k1_busy_n = 0;
    st0_hi_n = 0; st0_lo_n = 0; st0_rise_at = -1;
  endtask

  // Advance n edges, tallying outputs on each following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      for (int k = 0; k < 2; k++) begin
        if (key_press[k])   begin press_n[k]++; press_at[k] = edge_cnt; end
        if (key_release[k]) begin rel_n[k]++;   rel_at[k]   = edge_cnt; end
        if (key_long[k])    begin long_n[k]++;  long_at[k]  = edge_cnt; end
      end
      if (key_press == 2'b11) both_press_n++;
      if ({key_state, key_press, key_release, key_long} != 8'h00) busy_n++;
      if ({key_state[1], key_press[1], key_release[1], key_long[1]} != 4'h0) k1_busy_n++;
      if (key_state[0]) begin
        st0_hi_n++;
        if (st0_rise_at < 0) st0_rise_at = edge_cnt;
      end else begin
        st0_lo_n++;
      end
    end
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
      end
  endtask

  initial begin
    int e0;
    int p0;

    // 1. Reset and quiet idle
    sys_rst = 1'b0;
    key_in  = 2'b11;
    clr();
    #100;
    chk("rst_outputs", int'({key_state, key_press, key_release, key_long}), 0);
    #110;
    @(negedge sys_clk);
    sys_rst = 1'b1;
    step(500);
    chk("idle_busy_cycles", busy_n, 0);

    // 2. Clean press on key 0, then clean release
    clr();
    key_in[0] = 1'b0;
    e0 = edge_cnt + 1;
    step(40);
    chk("clean_press_count", press_n[0], 1);
    chk("clean_press_latency", press_at[0] - e0, LAT);
    chk("clean_state_rise_edge", st0_rise_at, e0 + LAT);
    chk("key1_quiet", k1_busy_n, 0);
    clr();
    key_in[0] = 1'b1;
    e0 = edge_cnt + 1;
    step(40);
    chk("clean_release_count", rel_n[0], 1);
    chk("clean_release_latency", rel_at[0] - e0, LAT);

    // 3. Bounce: 10 low, 3 high, 20 low, then high
    clr();
    key_in[0] = 1'b0; step(10);
    key_in[0] = 1'b1; step(3);
    key_in[0] = 1'b0; step(20);
    key_in[0] = 1'b1; step(40);
    chk("bounce_press_count", press_n[0], 0);
    chk("bounce_state_high_cycles", st0_hi_n, 0);
    clr();
    key_in[0] = 1'b0; step(40);
    chk("bounce_hold_press_count", press_n[0], 1);
    key_in[0] = 1'b1; step(40);

    // 4. Long press, then release
    clr();
    key_in[0] = 1'b0;
    step(300);
    chk("long_count", long_n[0], 1);
    chk("long_latency", long_at[0] - press_at[0], LLAT);
    key_in[0] = 1'b1;
    e0 = edge_cnt + 1;
    step(40);
    chk("long_release_count", rel_n[0], 1);
    chk("long_release_latency", rel_at[0] - e0, LAT);
    chk("long_state_after_release", int'(key_state[0]), 0);
    chk("long_count_after_release", long_n[0], 1);

    // 5. Release glitch of 10 cycles while DOWN; hold count freezes for 11 edges
    clr();
    key_in[0] = 1'b0;
    step(50);
    p0 = press_at[0];
    chk("glitch_press_count", press_n[0], 1);
    clr();
    key_in[0] = 1'b1; step(10);
    key_in[0] = 1'b0; step(200);
    chk("glitch_release_count", rel_n[0], 0);
    chk("glitch_state_low_cycles", st0_lo_n, 0);
    chk("glitch_long_latency", long_at[0] - p0, LLAT + 11);
    key_in[0] = 1'b1; step(40);

    // 6. Both keys together, then reset mid-hold with keys still down
    clr();
    key_in = 2'b00;
    step(40);
    chk("both_press_cycles", both_press_n, 1);
    chk("both_state", int'(key_state), 3);
    #5 sys_rst = 1'b0;
    #1;
    chk("midhold_rst_outputs", int'({key_state, key_press, key_release, key_long}), 0);
    step(3);
    sys_rst = 1'b1;
    clr();
    e0 = edge_cnt + 1;
    step(40);
    chk("post_rst_both_press_cycles", both_press_n, 1);
    chk("post_rst_press_latency", press_at[1] - e0, LAT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
